kth_largest_stream: RTL
=======================

# kth_largest_stream

Parametrised K-th-largest tracker for a stream of ALU results, the next generation of the fixed 8-bit, third-largest collector. It accepts a packet of samples under a valid/ready handshake and keeps a sorted top-K array on the fly. After the last beat it presents the K-th largest value, a found flag and the sample count, held until the consumer accepts them. It sits directly downstream of the ALU result bus.

## Interface
- WIDTH, 8: sample width in bits.
- K, 3: rank to report (1 = maximum); legal range 1..16.
- DISTINCT, 1: 1 = equal values count once (duplicates dropped); 0 = duplicates occupy separate ranks.
- SIGNED, 0: 1 = two's-complement compare; 0 = unsigned compare.
- CNT_W, 16: width of the sample counter.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  WIDTH  sample (ALU result).
- in_last  in  1  beat is the last of the packet.
- abort  in  1  synchronous packet discard.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH  K-th largest value; 0 if not found.
- res_found  out  1  at least K ranks were filled.
- res_count  out  CNT_W  beats accepted in the packet, saturating at all-ones.

## Operation
- States:
  - IDLE (no packet open).
  - COLLECT (packet open).
  - DONE (result held).
- Beat accepted iff in_valid && in_ready.
- in_ready = 1 in IDLE and COLLECT, 0 in DONE.
- Accepted beat in IDLE: clear the array, occupancy and count, then insert this beat in the same cycle. The first beat is never lost.
- Next state after an accepted IDLE beat: COLLECT, or DONE if in_last.
- COLLECT, accepted beat: insert it and increment the count. If in_last, go to DONE.
- Insert rule, array top[0..K-1] in descending order, occ in 0..K:
  - p = number of occupied entries strictly greater than in_data (DISTINCT=1) or greater-or-equal (DISTINCT=0).
  - DISTINCT=1 and in_data equals an occupied entry: array unchanged, count still increments.
  - p < K: entries p..K-2 shift down one, top[p] = in_data, occ = min(occ+1, K).
  - p = K: drop the sample.
- Compare is signed or unsigned per SIGNED. No arithmetic on samples; no width extension.
- Entering DONE: register the outputs.
  - res_found = (occ==K).
  - res_data = top[K-1] if found, else 0.
  - res_count = final count.
- DONE: res_valid = 1 and outputs stable until res_valid && res_ready, then go to IDLE.
- abort, sampled high:
  - In COLLECT: go to IDLE; any beat in that cycle is discarded.
  - In DONE: ignored.
  - Simultaneous with an accepted beat: abort wins.
- Count saturates at 2^CNT_W-1; the array keeps updating after saturation.

## Timing
- Reset values: in_ready 0 while rst_n is low, 1 from the first clock after release. res_valid 0, res_data 0, res_found 0, res_count 0, state IDLE, array and occ cleared.
- Latency: res_valid rises on the clock edge after the in_last beat is accepted.
- Single-beat packet (in_last on the IDLE beat) behaves identically.
- Handshake: res_valid held with stable data while res_ready is low. Zero-wait handshake allowed.
- in_ready returns high the cycle after the result handshake. Beats offered while in_ready is low are not consumed.
- Throughput: one beat per cycle; minimum two cycles of result gap between packets.
- rst_n asserted mid-packet or while res_valid is high: immediate return to all reset values; no partial result is emitted.

## Structure
- Shared package kth_pkg:
  - state enum {IDLE, COLLECT, DONE}.
  - Default parameter constants.
  - Compare helper function, parameterised by SIGNED.
- Sub-module kth_rank_array:
  - Owns top[], occ, the insert/shift logic and the clear.
  - Ports: clk, rst_n, clr, ins, din; outputs kth, full.
- Top level holds the FSM, counter, handshakes and output registers.

## Test plan
- K=3, DISTINCT=1, stream 5,9,2,9,7(last) -> res_data 5, res_found 1, res_count 5, res_valid one cycle after the last beat.
- DISTINCT=0, same stream -> top 9,9,7; res_data 7, res_found 1, res_count 5.
- DISTINCT=1, stream 4,4,4(last) -> occ 1, res_found 0, res_data 0, res_count 3.
- SIGNED=1, stream 0x80,0x7F,0xFF,0x01(last) -> ranks 127,1,-1; res_data 0xFF.
- res_ready low 4 cycles after a result -> res_valid and data held, in_ready 0, offered beats unconsumed. After the handshake, single beat 0x33(last) -> res_found 0, res_data 0, res_count 1.
- rst_n pulsed low after 2 beats -> all outputs at reset values. Next packet 1,2,3(last) -> res_data 1, res_count 3.
- abort in COLLECT together with a beat of 0xFF -> return to IDLE. Next packet 3,2,1(last) -> res_data 1.

Source files
------------

// File: rtl/kth_pkg.sv
// Shared types, default parameters and the sample compare helper for the
// K-th-largest stream tracker.
package kth_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_K        = 3;
  localparam int unsigned DEF_DISTINCT = 1;
  localparam int unsigned DEF_SIGNED   = 0;
  localparam int unsigned DEF_CNT_W    = 16;

  // a > b from the unsigned result and both MSBs; differing signs decide a signed compare
  function automatic logic cmp_gt(input logic a_msb, input logic b_msb,
                                  input logic ugt, input logic sgn);
    return (sgn && (a_msb != b_msb)) ? b_msb : ugt;
  endfunction

endpackage

// File: rtl/kth_largest_stream_if.sv
// Sample stream and result handshake bundle of the K-th-largest tracker.
interface kth_largest_stream_if
  import kth_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             abort;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_found;
  logic [CNT_W-1:0] res_count;

  modport master (
    output in_valid, in_data, in_last, abort, res_ready,
    input  in_ready, res_valid, res_data, res_found, res_count
  );

  modport slave (
    input  in_valid, in_data, in_last, abort, res_ready,
    output in_ready, res_valid, res_data, res_found, res_count
  );
endinterface

// File: rtl/kth_rank_array.sv
// Descending top-K array with occupancy; kth/full present the post-update
// values so the caller can register them on the same edge as the insert.
module kth_rank_array
  import kth_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned K        = DEF_K,
  parameter int unsigned DISTINCT = DEF_DISTINCT,
  parameter int unsigned SIGNED   = DEF_SIGNED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ins,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] kth,
  output logic             full
);
  localparam int unsigned OCC_W = $clog2(K + 1);
  localparam logic        SGN   = (SIGNED != 0);
  localparam logic        DIST  = (DISTINCT != 0);

  logic [WIDTH-1:0] top_q [K];
  logic [WIDTH-1:0] base  [K];
  logic [WIDTH-1:0] top_d [K];
  logic [OCC_W-1:0] occ_q, occ_b, occ_d;
  logic [K-1:0]     used, eq, ahead;
  logic             do_ins;

  // ahead[i]: entry i keeps its rank above din; sorted order makes this a prefix
  always_comb begin
    occ_b = clr ? '0 : occ_q;
    for (int i = 0; i < K; i++) begin
      base[i]  = clr ? '0 : top_q[i];
      used[i]  = (OCC_W'(i) < occ_b);
      eq[i]    = used[i] && (base[i] == din);
      ahead[i] = used[i] && (cmp_gt(base[i][WIDTH-1], din[WIDTH-1], base[i] > din, SGN)
                             || (!DIST && eq[i]));
    end
    do_ins = ins && !ahead[K-1] && !(DIST && (|eq));
    occ_d  = (do_ins && (occ_b != OCC_W'(K))) ? occ_b + 1'b1 : occ_b;
  end

  for (genvar g = 0; g < K; g++) begin : g_slot
    if (g == 0) begin : g_head
      assign top_d[g] = (!do_ins || ahead[g]) ? base[g] : din;
    end else begin : g_tail
      assign top_d[g] = (!do_ins || ahead[g]) ? base[g] :
                        ahead[g-1]            ? din     : base[g-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
      for (int i = 0; i < K; i++) top_q[i] <= '0;
    end else begin
      occ_q <= occ_d;
      for (int i = 0; i < K; i++) top_q[i] <= top_d[i];
    end
  end

  assign kth  = top_d[K-1];
  assign full = (occ_d == OCC_W'(K));
endmodule

// File: rtl/kth_largest_stream.sv
// K-th-largest tracker over one packet of samples; result held under a
// valid/ready handshake until the consumer takes it.
module kth_largest_stream
  import kth_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned K        = DEF_K,
  parameter int unsigned DISTINCT = DEF_DISTINCT,
  parameter int unsigned SIGNED   = DEF_SIGNED,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  kth_largest_stream_if.slave   bus
);
  state_t           state_q, state_d;
  logic             clr, ins, load, accept;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_q, valid_q, found_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] kth;
  logic             full;

  assign accept = bus.in_valid && rdy_q;

  kth_rank_array #(
    .WIDTH(WIDTH), .K(K), .DISTINCT(DISTINCT), .SIGNED(SIGNED)
  ) u_rank (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ins(ins), .din(bus.in_data),
    .kth(kth), .full(full)
  );

  // First beat of a packet clears and inserts in one cycle; abort only applies mid-packet
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    ins     = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          clr     = 1'b1;
          ins     = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = bus.in_last ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (accept) begin
          ins = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (bus.in_last) state_d = DONE;
        end
      end
      DONE: begin
        if (valid_q && bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign load = (state_d == DONE) && (state_q != DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      found_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_d != DONE);
      if (load) begin
        valid_q <= 1'b1;
        found_q <= full;
        data_q  <= full ? kth : '0;
        count_q <= cnt_d;
      end else if (state_q == DONE && bus.res_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.res_valid = valid_q;
  assign bus.res_data  = data_q;
  assign bus.res_found = found_q;
  assign bus.res_count = count_q;
endmodule
